// File: rtl/tw_mul_stage.sv
// -----------------------------------------------------------------------------
// tw_mul_stage
//   Twiddle-multiply stage of an NTT butterfly (modulus q = 3329).
//   Four-stage pipeline, one sample per cycle, no backpressure:
//     S1  register inputs
//     S2  p = v*w (or v itself in bypass)
//     S3  t = (p*5039) >> 24 (Barrett quotient estimate), carry p
//     S4  r = p - t*q, one conditional subtract of q -> v_out
//   u, sel and mul_en ride alongside in delay-matched registers.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears every pipeline register
//   flush      synchronous clear of all stage valids (data left untouched)
//   in_valid   qualifies u_in, v_in, w_in, mul_en, sel_in
//   mul_en     1: v_out = v_in*w_in mod q, 0: v_out = v_in unchanged
//   sel_in     butterfly control tag carried with the data
//   u_in       upper operand, delay-matched only
//   v_in       lower operand (multiplicand)
//   w_in       twiddle factor
//   out_valid  qualifies u_out, v_out, sel_out (latency 4 cycles)
//   u_out      delayed u_in
//   v_out      reduced product or bypassed v_in
//   sel_out    delayed sel_in
// -----------------------------------------------------------------------------
module tw_mul_stage #(
  parameter int data_width = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  mul_en,
  input  logic                  sel_in,
  input  logic [data_width-1:0] u_in,
  input  logic [data_width-1:0] v_in,
  input  logic [data_width-1:0] w_in,
  output logic                  out_valid,
  output logic [data_width-1:0] u_out,
  output logic [data_width-1:0] v_out,
  output logic                  sel_out
);

  localparam int p_w       = 2 * data_width;  // full product width
  localparam int r_w       = data_width + 1;  // Barrett remainder width, r < 2q
  localparam int q         = 3329;
  localparam int barrett_m = 5039;            // floor(2^24 / q)

  // S1
  logic                  s1_valid, s1_en, s1_sel;
  logic [data_width-1:0] s1_u, s1_v, s1_w;
  // S2
  logic                  s2_valid, s2_en, s2_sel;
  logic [data_width-1:0] s2_u;
  logic [p_w-1:0]        s2_p;
  // S3: only the low r_w bits of p matter from here on, because the true
  // remainder p - t*q fits in r_w bits and modular subtraction in that
  // width is exact. The bypass value also lives in those low bits.
  logic                  s3_valid, s3_en, s3_sel;
  logic [data_width-1:0] s3_u;
  logic [r_w-1:0]        s3_p;
  logic [r_w-1:0]        s3_t;

  logic [r_w-1:0]        t_next;
  logic [r_w-1:0]        r_raw;
  logic [data_width-1:0] v_red;
  logic [data_width-1:0] v_next;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    t_next = '0;
    r_raw  = '0;
    v_red  = '0;
    v_next = '0;
    // Quotient estimate; at most 1 below the true quotient, so r < 2q.
    t_next = r_w'((s2_p * (p_w + r_w)'(barrett_m)) >> p_w);
    r_raw  = s3_p - r_w'(s3_t * r_w'(q));
    v_red  = (r_raw >= r_w'(q)) ? data_width'(r_raw - r_w'(q)) : r_raw[data_width-1:0];
    v_next = s3_en ? v_red : s3_p[data_width-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // stage samples the previous stage's value from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared along with the valids so the
      // outputs read 0 after reset, not just out_valid.
      s1_valid  <= 1'b0; s1_en <= 1'b0; s1_sel <= 1'b0;
      s1_u      <= '0;   s1_v  <= '0;   s1_w   <= '0;
      s2_valid  <= 1'b0; s2_en <= 1'b0; s2_sel <= 1'b0;
      s2_u      <= '0;   s2_p  <= '0;
      s3_valid  <= 1'b0; s3_en <= 1'b0; s3_sel <= 1'b0;
      s3_u      <= '0;   s3_p  <= '0;   s3_t   <= '0;
      out_valid <= 1'b0;
      u_out     <= '0;
      v_out     <= '0;
      sel_out   <= 1'b0;
    end else begin
      // Data path loads every cycle; only the valid chain is qualified.
      s1_u   <= u_in;
      s1_v   <= v_in;
      s1_w   <= w_in;
      s1_en  <= mul_en;
      s1_sel <= sel_in;

      s2_u   <= s1_u;
      s2_en  <= s1_en;
      s2_sel <= s1_sel;
      s2_p   <= s1_en ? p_w'(s1_v) * p_w'(s1_w) : p_w'(s1_v);

      s3_u   <= s2_u;
      s3_en  <= s2_en;
      s3_sel <= s2_sel;
      s3_p   <= s2_p[r_w-1:0];
      s3_t   <= t_next;

      u_out   <= s3_u;
      v_out   <= v_next;
      sel_out <= s3_sel;

      // Flush wins over in_valid: a coincident sample is dropped.
      s1_valid  <= in_valid & ~flush;
      s2_valid  <= s1_valid & ~flush;
      s3_valid  <= s2_valid & ~flush;
      out_valid <= s3_valid & ~flush;
    end
  end

endmodule

// File: tb/tb_tw_mul_stage.sv
// -----------------------------------------------------------------------------
// tb_tw_mul_stage
//   Scoreboard bench for tw_mul_stage. The driver pushes the expected
//   response (with the cycle it must appear in) for every accepted sample;
//   a monitor on the falling edge pops and compares whenever out_valid is 1.
// -----------------------------------------------------------------------------
module tb_tw_mul_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, mul_en, sel_in;
  logic [11:0] u_in, v_in, w_in;
  logic        out_valid, sel_out;
  logic [11:0] u_out, v_out;

  tw_mul_stage #(.data_width(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .mul_en   (mul_en),
    .sel_in   (sel_in),
    .u_in     (u_in),
    .v_in     (v_in),
    .w_in     (w_in),
    .out_valid(out_valid),
    .u_out    (u_out),
    .v_out    (v_out),
    .sel_out  (sel_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] u;
    logic [11:0] v;
    logic        sel;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   errors  = 0;
  int   checks  = 0;
  int   run     = 0;
  int   max_run = 0;
  int   seen    = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain modular arithmetic, independent of the Barrett datapath.
  function automatic int model(input int v, input int w, input bit en);
    return en ? (v * w) % 3329 : v;
  endfunction

  // Drop expectations that a flush/reset issued in cycle c kills: anything
  // not already on the outputs during cycle c.
  task automatic prune(input int c);
    exp_t keep[$];
    foreach (sb[i]) if (sb[i].exp_cyc <= c) keep.push_back(sb[i]);
    sb = keep;
  endtask

  task automatic drive(input bit vld, input bit en, input bit sel,
                       input int u, input int v, input int w, input int ev,
                       input bit fl = 1'b0, input bit r = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    flush    = fl;
    in_valid = vld;
    mul_en   = en;
    sel_in   = sel;
    u_in     = 12'(u);
    v_in     = 12'(v);
    w_in     = 12'(w);
    if (fl || r) prune(cyc);
    else if (vld) begin
      e.u = 12'(u); e.v = 12'(ev); e.sel = sel; e.exp_cyc = cyc + 4;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      seen++;
      run++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got v_out=%0d u_out=%0d, expected no output (cycle %0d)",
                 v_out, u_out, cyc);
      end else begin
        e = sb.pop_front();
        check("v_out",   32'(v_out),   32'(e.v));
        check("u_out",   32'(u_out),   32'(e.u));
        check("sel_out", 32'(sel_out), 32'(e.sel));
        check("latency", 32'(cyc),     32'(e.exp_cyc));
      end
    end else begin
      if (run > max_run) max_run = run;
      run = 0;
    end
  end

  initial begin
    int s0, v, w;
    bit en;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mul_en = 1'b0; sel_in = 1'b0;
    u_in = '0; v_in = '0; w_in = '0;

    // Reset state
    repeat (3) drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_u_out",     32'(u_out),     0);
    check("rst_v_out",     32'(v_out),     0);
    check("rst_sel_out",   32'(sel_out),   0);
    idle(2);

    // Directed vectors, hand-computed results
    drive(1'b1, 1'b1, 1'b1, 100,  1,    17,   17);   // identity
    drive(1'b1, 1'b1, 1'b0, 7,    3328, 3328, 1);    // (-1)^2
    drive(1'b1, 1'b1, 1'b1, 4095, 4095, 4095, 852);  // operands >= q
    drive(1'b1, 1'b0, 1'b0, 55,   4000, 9,    4000); // bypass, no reduction
    drive(1'b1, 1'b1, 1'b0, 1,    0,    4095, 0);    // zero operand
    drive(1'b1, 1'b1, 1'b1, 2,    3329, 2,    0);    // v == q
    idle(2);                                         // 2-cycle gap
    drive(1'b1, 1'b1, 1'b0, 3,    2,    1665, 1);    // 3330 mod q
    drive(1'b1, 1'b1, 1'b1, 4,    100,  100,  10000 - 3*3329);
    idle(8);

    // Streaming: 64 back-to-back samples
    max_run = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 20) begin
        drive(1'b1, 1'b0, 1'b1, i, 1234, 777, 1234);
      end else begin
        v  = int'($urandom_range(4095));
        w  = int'($urandom_range(4095));
        en = ($urandom_range(3) != 0);
        drive(1'b1, en, 1'(i), i, v, w, model(v, w, en));
      end
    end
    idle(8);
    check("stream_run", 32'(max_run), 64);

    // Flush coincident with a 4th input: none of the four emerge
    drive(1'b1, 1'b1, 1'b1, 11, 5, 6, 30);
    drive(1'b1, 1'b1, 1'b0, 12, 7, 8, 56);
    drive(1'b1, 1'b1, 1'b1, 13, 9, 10, 90);
    s0 = seen;
    drive(1'b1, 1'b1, 1'b0, 14, 11, 12, 132, 1'b1, 1'b0);
    idle(8);
    check("flush_outputs", 32'(seen - s0), 0);

    // Reset mid-stream, then one sample with exact latency
    drive(1'b1, 1'b1, 1'b1, 21, 5, 6, 30);
    drive(1'b1, 1'b1, 1'b0, 22, 7, 8, 56);
    drive(1'b1, 1'b1, 1'b1, 23, 9, 10, 90);
    s0 = seen;
    drive(1'b1, 1'b1, 1'b1, 24, 11, 12, 132, 1'b0, 1'b1);
    idle(1);
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_u_out",     32'(u_out),     0);
    check("mid_rst_v_out",     32'(v_out),     0);
    check("mid_rst_sel_out",   32'(sel_out),   0);
    idle(6);
    check("rst_outputs", 32'(seen - s0), 0);
    drive(1'b1, 1'b1, 1'b1, 99, 3000, 3000, model(3000, 3000, 1'b1));
    idle(8);

    check("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
